led_ctrl: RTL
=============

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter N, default 4: number of button/LED channels; legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 16: debounce qualification length in clk cycles; legal range >= 2.
REQ-003 Parameter BLINK_DIV, default 20: blink prescaler width in bits; legal range >= 2.
REQ-004 clk  input  1: single clock; all state SHALL update on the rising edge only.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 btn  input  N: raw, asynchronous push-button levels, 1 = pressed.
REQ-007 mode  input  2N: per-channel mode; bits [2i+1:2i] control channel i; synchronous to clk.
REQ-008 led  output  N: registered LED drive, 1 = lit.
REQ-009 btn_press  output  N: registered one-cycle pulse per debounced press (0->1 of the debounced level).

Function
REQ-010 Each btn[i] SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-011 Each channel SHALL hold a debounced level stb[i] and a counter cnt[i] of width $clog2(DEB_CYCLES)+1.
REQ-012 Counter rule per edge: sync2 == stb -> cnt <= 0; sync2 != stb and cnt < DEB_CYCLES-1 -> cnt <= cnt+1; sync2 != stb and cnt == DEB_CYCLES-1 -> stb <= sync2, cnt <= 0.
REQ-013 A glitch shorter than DEB_CYCLES cycles at sync2 SHALL NOT change stb; any return to the stb value SHALL clear cnt.
REQ-014 Latency: btn[i] changes and is held stable, first sampled at edge k -> stb[i] updates at edge k+1+DEB_CYCLES.
REQ-015 Rise detect: rise[i] = stb[i] & ~stb_q[i], where stb_q is stb delayed one edge; btn_press[i] <= rise[i], so it is high for exactly one cycle after edge k+2+DEB_CYCLES.
REQ-016 Per-channel toggle register tgl[i] SHALL invert on every edge where rise[i] = 1, regardless of mode; it is unaffected by mode changes.
REQ-017 Blink prescaler: one free-running BLINK_DIV-bit counter shared by all channels, incrementing every edge and wrapping to 0 after all-ones; phase = counter MSB, giving a period of 2^BLINK_DIV cycles at 50% duty.
REQ-018 Modes, led[i] <= value each edge: 00 direct = stb[i]; 01 toggle = tgl[i]; 10 blink = tgl[i] & phase; 11 inverted = ~stb[i].
REQ-019 Mode 00 led lags stb by one edge; mode 01 led lags the tgl flip by one edge, i.e. it updates at edge k+3+DEB_CYCLES.
REQ-020 A mode change SHALL take effect at the next edge with no glitch and no change to stb, cnt, tgl or the prescaler.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several channels SHALL each produce their own btn_press pulse in the same cycle.
REQ-022 A release (stb 1->0) SHALL NOT assert btn_press and SHALL NOT flip tgl.

Reset
REQ-023 rst_n = 0 SHALL immediately clear sync1, sync2, stb, stb_q, cnt, tgl, the prescaler, led and btn_press to 0.
REQ-024 Reset asserted mid-debounce or mid-blink SHALL discard all progress; after release, a still-pressed button requires the full REQ-014 latency to register.
REQ-025 In mode 11, led SHALL read 0 during reset and 1 from the first edge after reset release.

Verification (N=4, DEB_CYCLES=4, BLINK_DIV=3)
REQ-026 Debounce latency: btn[0] 0->1 held, mode 00, first sampled at edge k -> stb[0] = 1 at edge k+5, led[0] = 1 at edge k+6, btn_press[0] = 1 for exactly one cycle after edge k+6.
REQ-027 Glitch reject: btn[1] high for 3 cycles, then low -> led[1], btn_press[1] and tgl[1] stay 0 throughout.
REQ-028 Toggle: mode 01, two clean press/release pairs on btn[2] -> led[2] goes 0 -> 1 -> 0, with exactly 2 btn_press[2] pulses and no pulse on release.
REQ-029 Blink: mode 10 with tgl[3] = 1 -> led[3] alternates in runs of 4 cycles high and 4 cycles low; tgl[3] = 0 -> led[3] held at 0.
REQ-030 Inverted and simultaneous events: all channels in mode 11, all btn pressed in the same cycle -> all four led go 1 -> 0 on the same edge, and btn_press = 4'b1111 for one cycle.
REQ-031 Reset mid-operation: assert rst_n low while cnt[0] = 2 and led is blinking -> all outputs 0 immediately; after release, the held button needs the full 5-edge stb latency.

Source files
------------

// File: rtl/led_ctrl.sv
// -----------------------------------------------------------------------------
// led_ctrl
//   Per-channel push-button debouncer and LED driver.
//   Each raw button is synchronised through two flops and then debounced.
//   Every debounced press emits a one-cycle pulse and flips a toggle bit.
//   The LED shows one of four views: direct, toggle, blinking toggle or
//   inverted. The blink phase comes from one shared free-running prescaler.
//
// Parameters
//   N           number of channels (1..32)
//   DEB_CYCLES  edges a new synchronised level must persist (>= 2)
//   BLINK_DIV   prescaler width; blink period is 2^BLINK_DIV cycles (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   btn        raw button levels, 1 = pressed (asynchronous)
//   mode       two bits per channel: 00 direct, 01 toggle, 10 blink,
//              11 inverted
//   led        registered LED drive, 1 = lit
//   btn_press  registered one-cycle pulse per debounced press
// -----------------------------------------------------------------------------
module led_ctrl #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     btn,
  input  logic [2*N-1:0]   mode,
  output logic [N-1:0]     led,
  output logic [N-1:0]     btn_press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [N-1:0]           r_sync1;
  logic [N-1:0]           r_sync2;
  logic [N-1:0]           r_stb;
  logic [N-1:0]           r_stb_q;
  logic [N-1:0]           r_tgl;
  logic [N-1:0]           r_led;
  logic [N-1:0]           r_press;
  logic [CW-1:0]          r_cnt [N];
  logic [BLINK_DIV-1:0]   r_presc;

  logic [N-1:0]           w_rise;
  logic [N-1:0]           w_led_next;
  logic                   w_phase;

  // A press is the 0->1 edge of the debounced level; releases never count.
  assign w_rise  = r_stb & ~r_stb_q;
  assign w_phase = r_presc[BLINK_DIV-1];

  // Synchroniser and debounce counters. The counter only runs while the
  // synchronised input disagrees with the debounced level; any agreement
  // clears it, so a short glitch leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_stb   <= '0;
      r_stb_q <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_stb_q <= r_stb;
      for (int i = 0; i < N; i++) begin
        if (r_sync2[i] == r_stb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // LED view selection from the current (pre-edge) register values.
  always_comb begin
    w_led_next = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        2'b00:   w_led_next[i] = r_stb[i];
        2'b01:   w_led_next[i] = r_tgl[i];
        2'b10:   w_led_next[i] = r_tgl[i] & w_phase;
        default: w_led_next[i] = ~r_stb[i];
      endcase
    end
  end

  // Toggle bits, shared prescaler and registered outputs. Mode only
  // steers the LED mux, so changing it never disturbs tgl or the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgl   <= '0;
      r_presc <= '0;
      r_led   <= '0;
      r_press <= '0;
    end else begin
      r_tgl   <= r_tgl ^ w_rise;
      r_presc <= r_presc + 1'b1;
      r_led   <= w_led_next;
      r_press <= w_rise;
    end
  end

  assign led       = r_led;
  assign btn_press = r_press;

endmodule
